// File: rtl/snes_pad_responder_if.sv
// Console-side SNES pad link plus the CPU button-injection port, grouped for the responder.
interface snes_pad_responder_if;
    logic        CTRL_LATCH_i;
    logic        CTRL_CLK_i;
    logic        PAD_SDATA_i;
    logic        CTRL_SDATA_o;
    logic        EMU_EN_i;
    logic [11:0] BTN_i;
    logic        BTN_WR_i;
    logic        BTN_ACK_o;
    logic        POLL_o;
    logic [4:0]  BIT_CNT_o;

    modport master (
        output CTRL_LATCH_i,
        output CTRL_CLK_i,
        output PAD_SDATA_i,
        output EMU_EN_i,
        output BTN_i,
        output BTN_WR_i,
        input  CTRL_SDATA_o,
        input  BTN_ACK_o,
        input  POLL_o,
        input  BIT_CNT_o
    );

    modport slave (
        input  CTRL_LATCH_i,
        input  CTRL_CLK_i,
        input  PAD_SDATA_i,
        input  EMU_EN_i,
        input  BTN_i,
        input  BTN_WR_i,
        output CTRL_SDATA_o,
        output BTN_ACK_o,
        output POLL_o,
        output BIT_CNT_o
    );
endinterface

// File: rtl/snes_pad_responder.sv
// SNES controller emulator: answers console latch/clock polling with a 16-bit button frame,
// or passes the physical pad through when emulation is disabled.
module snes_pad_responder #(
    parameter int unsigned        NBITS       = 16,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        TIMEOUT     = 1024,
    parameter int unsigned        TO_W        = 11,
    parameter logic [NBITS-13:0]  ID_BITS     = 4'hF,
    parameter logic               POST_LEVEL  = 1'b0
) (
    input  logic                  CLK_i,
    input  logic                  NRST_i,
    snes_pad_responder_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(NBITS + 1);
    localparam int unsigned IDX_W = $clog2(NBITS);

    typedef enum logic [1:0] {StIdle, StLatched, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]     frame_q, frame_d;
    logic                 emu_q, emu_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [11:0]          pending_q, pending_d;
    logic                 poll_q, poll_d;
    logic                 ack_q;
    logic                 pad_q;

    logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
    logic                   latch_prev_q, clk_prev_q;
    logic                   latch_lvl, latch_rise, latch_fall, clk_rise;
    logic [11:0]            pend_eff;
    logic [NBITS-1:0]       new_frame;
    logic                   sdata;

    // The console clock idles high, so its synchroniser resets high to avoid a false rise.
    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '1;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b1;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], bus.CTRL_LATCH_i};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], bus.CTRL_CLK_i};
            latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
            clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign latch_lvl  = latch_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_lvl & ~latch_prev_q;
    assign latch_fall = ~latch_lvl & latch_prev_q;
    assign clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

    // A write in the capture cycle is seen by the frame being built (write-through).
    assign pend_eff  = bus.BTN_WR_i ? bus.BTN_i : pending_q;
    assign new_frame = {ID_BITS, ~pend_eff};

    always_comb begin
        pending_d = bus.BTN_WR_i ? bus.BTN_i : pending_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        emu_d     = emu_q;
        to_cnt_d  = to_cnt_q;
        poll_d    = 1'b0;

        if (latch_rise) begin
            // Latch rise aborts whatever frame is open and wins over a coincident clock edge.
            state_d   = StLatched;
            frame_d   = new_frame;
            emu_d     = bus.EMU_EN_i;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StLatched: begin
                    if (latch_fall) begin
                        state_d  = StShift;
                        to_cnt_d = '0;
                    end else if (latch_lvl) begin
                        frame_d   = new_frame;
                        bit_cnt_d = '0;
                    end
                end
                StShift: begin
                    if (clk_rise) begin
                        to_cnt_d = '0;
                        if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                            bit_cnt_d = CNT_W'(NBITS);
                            poll_d    = 1'b1;
                            state_d   = StDone;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                StIdle, StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            frame_q   <= '1;
            emu_q     <= 1'b0;
            to_cnt_q  <= '0;
            pending_q <= '0;
            poll_q    <= 1'b0;
            ack_q     <= 1'b0;
            pad_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            emu_q     <= emu_d;
            to_cnt_q  <= to_cnt_d;
            pending_q <= pending_d;
            poll_q    <= poll_d;
            ack_q     <= bus.BTN_WR_i;
            pad_q     <= bus.PAD_SDATA_i;
        end
    end

    always_comb begin
        sdata = pad_q;
        if (emu_q) begin
            if (state_q == StIdle) begin
                sdata = 1'b1;
            end else if (bit_cnt_q == CNT_W'(NBITS)) begin
                sdata = POST_LEVEL;
            end else begin
                sdata = frame_q[bit_cnt_q[IDX_W-1:0]];
            end
        end
    end

    assign bus.CTRL_SDATA_o = sdata;
    assign bus.BIT_CNT_o    = 5'(bit_cnt_q);
    assign bus.POLL_o       = poll_q;
    assign bus.BTN_ACK_o    = ack_q;

endmodule
